// File: rtl/a25_wb_burst_arbiter.sv
// a25_wb_burst_arbiter: round-robin owner of the a25 Wishbone master port.
//
// Grants one of N_REQ internal requesters at a time and sequences a single
// beat or a 4-beat incrementing burst for it. Addresses and data are muxed
// outside this block using o_grant and o_beat. A requester may hold the bus
// across back-to-back transfers (swap) with i_req_lock. A transfer that
// stalls for TIMEOUT strobe cycles is aborted.
//
// Ports
//   i_clk          system clock, rising edge
//   quick_n_reset  asynchronous active-low reset
//   i_req          per-requester request, held until o_req_done
//   i_req_burst    1 = 4-beat burst, 0 = single beat
//   i_req_we       1 = write
//   i_req_lock     keep bus ownership after this transfer
//   o_grant        one-hot owner, zero when the bus is free
//   o_req_done     one-cycle pulse to the owner when its transfer ends
//   o_req_err      qualifies o_req_done: ended by i_wb_err or timeout
//   o_wb_cyc       Wishbone cycle
//   o_wb_stb       Wishbone strobe
//   o_wb_we        Wishbone write enable
//   o_wb_cti       3'b010 incrementing beat, 3'b111 last/single beat
//   o_beat         current beat index
//   i_wb_ack       slave acknowledge
//   i_wb_err       slave error
//   o_timeout      one-cycle pulse on watchdog abort
module a25_wb_burst_arbiter #(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 1000,
    parameter int TO_W    = 10
) (
    input  logic             i_clk,
    input  logic             quick_n_reset,
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_req_burst,
    input  logic [N_REQ-1:0] i_req_we,
    input  logic [N_REQ-1:0] i_req_lock,
    output logic [N_REQ-1:0] o_grant,
    output logic [N_REQ-1:0] o_req_done,
    output logic             o_req_err,
    output logic             o_wb_cyc,
    output logic             o_wb_stb,
    output logic             o_wb_we,
    output logic [2:0]       o_wb_cti,
    output logic [1:0]       o_beat,
    input  logic             i_wb_ack,
    input  logic             i_wb_err,
    output logic             o_timeout
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t            r_state, w_state;
    logic [PW-1:0]     r_ptr, w_ptr;
    logic [N_REQ-1:0]  r_grant, w_grant;
    logic [N_REQ-1:0]  r_done, w_done;
    logic              r_err, w_err;
    logic              r_cyc, w_cyc;
    logic              r_stb, w_stb;
    logic              r_we, w_we;
    logic              r_burst, w_burst;
    logic              r_lock, w_lock;
    logic [2:0]        r_cti, w_cti;
    logic [1:0]        r_beat, w_beat;
    logic              r_to, w_to;
    logic [TO_W-1:0]   r_wdog, w_wdog;

    logic [PW-1:0]     w_pick, w_ptr_nxt;
    logic [PW:0]       w_d, w_best;
    logic [N_REQ-1:0]  w_pick_oh;
    logic              w_last, w_wd_hit, w_own_lock;

    // Round-robin pick: requester with the smallest forward distance from r_ptr.
    always_comb begin
        w_pick = '0;
        w_best = '1;
        w_d    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_d = (PW'(i) >= r_ptr) ? {1'b0, PW'(i) - r_ptr}
                                    : {1'b0, PW'(i)} + (PW+1)'(N_REQ) - {1'b0, r_ptr};
            if (i_req[i] && w_d < w_best) begin
                w_best = w_d;
                w_pick = PW'(i);
            end
        end
    end

    assign w_pick_oh  = N_REQ'(1) << w_pick;
    assign w_ptr_nxt  = (w_pick == PW'(N_REQ-1)) ? '0 : w_pick + PW'(1);
    assign w_last     = r_burst ? (r_beat == 2'd3) : 1'b1;
    // An ack in the very cycle the count would reach TIMEOUT still counts as a beat.
    assign w_wd_hit   = (r_wdog == TO_W'(TIMEOUT-1)) && !i_wb_ack;
    assign w_own_lock = |(i_req_lock & r_grant);

    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_grant = r_grant;
        w_done  = '0;
        w_err   = 1'b0;
        w_cyc   = r_cyc;
        w_stb   = r_stb;
        w_we    = r_we;
        w_burst = r_burst;
        w_lock  = r_lock;
        w_beat  = r_beat;
        w_to    = 1'b0;
        w_wdog  = '0;
        unique case (r_state)
            IDLE: begin
                if (|i_req) begin
                    w_state = XFER;
                    w_grant = w_pick_oh;
                    w_cyc   = 1'b1;
                    w_stb   = 1'b1;
                    w_we    = |(i_req_we & w_pick_oh);
                    w_burst = |(i_req_burst & w_pick_oh);
                    w_beat  = 2'd0;
                    w_ptr   = w_ptr_nxt;
                end
            end
            XFER: begin
                if (i_wb_err || w_wd_hit) begin
                    // Abort always releases the bus, even under lock.
                    w_state = GAP;
                    w_stb   = 1'b0;
                    w_cyc   = 1'b0;
                    w_grant = '0;
                    w_done  = r_grant;
                    w_err   = 1'b1;
                    w_to    = !i_wb_err;
                    w_lock  = 1'b0;
                    w_beat  = 2'd0;
                end else if (i_wb_ack) begin
                    w_beat = w_last ? 2'd0 : r_beat + 2'd1;
                    if (w_last) begin
                        w_state = GAP;
                        w_stb   = 1'b0;
                        w_lock  = w_own_lock;
                        w_cyc   = w_own_lock;
                        w_grant = w_own_lock ? r_grant : '0;
                        w_done  = r_grant;
                    end
                end else begin
                    w_wdog = r_wdog + TO_W'(1);
                end
            end
            GAP: begin
                if (r_lock && |(i_req & r_grant)) begin
                    // Locked continuation: same owner, fresh attributes, no arbitration.
                    w_state = XFER;
                    w_stb   = 1'b1;
                    w_we    = |(i_req_we & r_grant);
                    w_burst = |(i_req_burst & r_grant);
                    w_beat  = 2'd0;
                end else begin
                    w_state = IDLE;
                    w_cyc   = 1'b0;
                    w_grant = '0;
                end
                w_lock = 1'b0;
            end
            default: w_state = IDLE;
        endcase
        w_cti = (w_state == XFER && w_burst && w_beat != 2'd3) ? 3'b010 : 3'b111;
    end

    always_ff @(posedge i_clk or negedge quick_n_reset) begin
        if (!quick_n_reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_burst <= 1'b0;
            r_lock  <= 1'b0;
            r_cti   <= 3'b111;
            r_beat  <= 2'd0;
            r_to    <= 1'b0;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_grant <= w_grant;
            r_done  <= w_done;
            r_err   <= w_err;
            r_cyc   <= w_cyc;
            r_stb   <= w_stb;
            r_we    <= w_we;
            r_burst <= w_burst;
            r_lock  <= w_lock;
            r_cti   <= w_cti;
            r_beat  <= w_beat;
            r_to    <= w_to;
            r_wdog  <= w_wdog;
        end
    end

    assign o_grant    = r_grant;
    assign o_req_done = r_done;
    assign o_req_err  = r_err;
    assign o_wb_cyc   = r_cyc;
    assign o_wb_stb   = r_stb;
    assign o_wb_we    = r_we;
    assign o_wb_cti   = r_cti;
    assign o_beat     = r_beat;
    assign o_timeout  = r_to;

endmodule
